// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: owns the PC and the instruction register of the MIPS core.
// It fetches one instruction at a time over a req/ready handshake, holds it
// for the datapath, and forms the next PC from the control unit's pc_src.
// Optional build macro: MIPS_FETCH_MISALIGN_TRAP_EN turns a PC with nonzero
// low bits (next PC or RESET_PC) into a sticky fetch_err and the ERR state.
module mips_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  function_bits,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        exec_done,
   input  logic [1:0]  pc_src,
   input  logic [31:0] jr_addr,
   output logic        fetch_err
);

   // Wait counter only has to reach MAX_WAIT-1: the MAX_WAIT-th idle cycle trips the error.
   localparam int unsigned    WCW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
   localparam logic BOOT_MISALIGN = (RESET_PC[1:0] != 2'b00);
`else
   localparam logic BOOT_MISALIGN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_BOOT  = 2'b00,
      ST_FETCH = 2'b01,
      ST_ISSUE = 2'b10,
      ST_ERR   = 2'b11
   } state_t;

   state_t         state_r;
   logic [31:0]    pc_r;
   logic [31:0]    instr_r;
   logic [WCW-1:0] wait_cnt_r;
   logic           imem_req_r;
   logic           instr_valid_r;
   logic           fetch_err_r;

   logic [31:0]    pc_plus4_s;
   logic [31:0]    br_off_s;
   logic [31:0]    next_pc_s;
   logic           misalign_s;

   // Next-PC selection from the control unit's decision (all 32-bit wrap-around).
   always_comb begin
      pc_plus4_s = pc_r + 32'd4;
      br_off_s   = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
      next_pc_s  = pc_plus4_s;
      case (pc_src)
         2'b00:   next_pc_s = pc_plus4_s;
         2'b01:   next_pc_s = pc_plus4_s + br_off_s;
         2'b10:   next_pc_s = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
         2'b11:   next_pc_s = jr_addr;
         default: next_pc_s = pc_plus4_s;
      endcase
   end

`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
   assign misalign_s = (next_pc_s[1:0] != 2'b00);
`else
   assign misalign_s = 1'b0;
`endif

   // Fetch/issue sequencer with registered request, valid and error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_BOOT;
         pc_r          <= RESET_PC;
         instr_r       <= 32'h0000_0000;
         wait_cnt_r    <= '0;
         imem_req_r    <= 1'b0;
         instr_valid_r <= 1'b0;
         fetch_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_BOOT: begin
               if (BOOT_MISALIGN) begin
                  state_r     <= ST_ERR;
                  fetch_err_r <= 1'b1;
                  imem_req_r  <= 1'b0;
               end else begin
                  state_r     <= ST_FETCH;
                  imem_req_r  <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem_ready) begin
                  instr_r       <= imem_rdata;
                  wait_cnt_r    <= '0;
                  imem_req_r    <= 1'b0;
                  instr_valid_r <= 1'b1;
                  state_r       <= ST_ISSUE;
               end else if (wait_cnt_r == WAIT_LAST) begin
                  wait_cnt_r    <= '0;
                  imem_req_r    <= 1'b0;
                  fetch_err_r   <= 1'b1;
                  state_r       <= ST_ERR;
               end else begin
                  wait_cnt_r    <= wait_cnt_r + WCW'(1);
               end
            end
            ST_ISSUE: begin
               if (exec_done) begin
                  // pc is written even when trapping so the offending value is visible.
                  pc_r          <= next_pc_s;
                  instr_valid_r <= 1'b0;
                  if (misalign_s) begin
                     fetch_err_r <= 1'b1;
                     imem_req_r  <= 1'b0;
                     state_r     <= ST_ERR;
                  end else begin
                     imem_req_r  <= 1'b1;
                     state_r     <= ST_FETCH;
                  end
               end else begin
                  state_r <= ST_ISSUE;
               end
            end
            ST_ERR: begin
               imem_req_r    <= 1'b0;
               instr_valid_r <= 1'b0;
               state_r       <= ST_ERR;
            end
            default: begin
               imem_req_r    <= 1'b0;
               instr_valid_r <= 1'b0;
               fetch_err_r   <= 1'b1;
               state_r       <= ST_ERR;
            end
         endcase
      end
   end

   assign imem_req      = imem_req_r;
   assign imem_addr     = pc_r;
   assign instr_valid   = instr_valid_r;
   assign instr         = instr_r;
   assign opcode        = instr_r[31:26];
   assign function_bits = instr_r[5:0];
   assign rs            = instr_r[25:21];
   assign rt            = instr_r[20:16];
   assign rd            = instr_r[15:11];
   assign imm           = instr_r[15:0];
   assign pc            = pc_r;
   assign pc_plus4      = pc_plus4_s;
   assign fetch_err     = fetch_err_r;

endmodule
